piso_32_tx: RTL

Parallel-in/serial-out transmitter for the 32-bit serial link. It accepts a 32-bit word over a valid/ready handshake and shifts it out one bit per `bit_en` strobe. Each bit is paired with a `serial_en` qualifier so it can drive the team's 32-bit SIPO receiver directly. Bit 0 goes first, so after 32 qualified shifts the receiver holds the original word.

---
 rtl/serial_link_pkg.sv | 24 ++
 rtl/piso_32_tx.sv | 81 ++++++++
 2 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the 32-bit serial link (PISO transmitter / SIPO receiver).
// Both ends shift LSB first, so bit 0 of a word is the first bit on the line.
package serial_link_pkg;

    localparam int LINK_WIDTH = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    typedef enum logic [0:0] {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } bit_order_t;

    localparam bit_order_t LINK_BIT_ORDER = LSB_FIRST;

    // Even parity of a link word, for integrity checks on either side of the link.
    function automatic logic word_parity(input logic [LINK_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/piso_32_tx.sv
// Parallel-in/serial-out transmitter: accepts a word on a valid/ready handshake and
// shifts it out LSB first, one bit per bit_en strobe, with a serial_en qualifier.
module piso_32_tx
    import serial_link_pkg::*;
#(
    parameter int WIDTH = LINK_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             bit_en,
    output logic             serial_out,
    output logic             serial_en,
    output logic             busy,
    output logic             done
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    tx_state_t        state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CNT_W-1:0] cnt_r;
    logic             done_r;
    logic             shifting_s;

    // FSM, shift register, bit counter and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            shreg_r <= '0;
            cnt_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load_valid) begin
                        shreg_r <= load_data;
                        cnt_r   <= '0;
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (bit_en) begin
                        shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
                        // The counter stops at its last value instead of wrapping.
                        if (cnt_r == CNT_LAST) begin
                            state_r <= IDLE;
                            done_r  <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    shreg_r <= '0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Line outputs are decoded only from registers, except the qualifier which follows bit_en.
    always_comb begin
        shifting_s = (state_r == SHIFT);
        load_ready = ~shifting_s;
        busy       = shifting_s;
        serial_out = shifting_s & shreg_r[0];
        serial_en  = shifting_s & bit_en;
        done       = done_r;
    end

endmodule
